interboard_receiver: RTL
========================

Name: interboard_receiver

Overview:
- Receive-side stage of the inter-board link: consumes the peer board's `Request_in` / `inter_data_in` / `Ack_in`-style 4-phase handshake and rebuilds complete game messages (type plus number).
- Sits directly downstream of the board pins and upstream of the game controller. It drives that controller's `interboard_en`, `interboard_msg_type`, `interboard_number` and `interboard_rst` inputs.
- Synchronises the asynchronous peer request, acknowledges every beat, assembles two-beat frames, and flags malformed or stalled frames.

Parameters:
- `TIMEOUT_CYC`, 1_000_000, max cycles to wait for beat 1 after beat 0 completes before the frame is abandoned.
- `RST_TYPE`, 3'd7, `msg_type` value that also fires `interboard_rst`.
- `SYNC_STAGES`, 2, flip-flop stages on `Request_in` (legal values 2..3).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `Request_in`  in  1  peer request, asynchronous to `clk`.
- `inter_data_in`  in  6  peer data, held stable by the sender while `Request_in` is high.
- `Ack_out`  out  1  acknowledge to peer.
- `interboard_en`  out  1  one-cycle pulse: a valid message is on the outputs.
- `interboard_msg_type`  out  3  message type, held until the next valid message.
- `interboard_number`  out  5  message number 0..24, held until the next valid message.
- `interboard_rst`  out  1  one-cycle pulse, coincident with `interboard_en` when type == `RST_TYPE`.
- `frame_err`  out  1  one-cycle pulse on a bad or abandoned frame.

Behaviour:
- **Frame format.**
  - Beat 0 = {1'b1, type[2:0], num[4:3]}.
  - Beat 1 = {1'b0, num[2:0], par[1:0]}, where par = {^type, ^num}.
  - Bit 5 is the beat marker.
- **Request synchronisation.** `req_s` is `Request_in` after `SYNC_STAGES` FFs. `inter_data_in` is sampled only when `req_s` is high; no data synchroniser is needed.
- **Reset.** All outputs are 0; the FSM is in IDLE; the timeout counter is 0; the capture registers are 0.
- **State IDLE.**
  - `req_s`=1 and data[5]=1: capture type and num_hi, set `Ack_out`<=1, go to ACK0.
  - `req_s`=1 and data[5]=0 (orphan beat 1): set `Ack_out`<=1, set bad flag, go to ACK0.
- **State ACK0.** When `req_s`=0: `Ack_out`<=0.
  - If bad flag: pulse `frame_err`, clear bad flag, go to IDLE.
  - Otherwise: clear the counter and go to WAIT1.
- **State WAIT1.**
  - `req_s`=1 and data[5]=0: capture num_lo and par, set `Ack_out`<=1, go to ACK1.
  - `req_s`=1 and data[5]=1 (new beat 0 arrives while beat 1 is expected): pulse `frame_err`, treat the beat as a fresh beat 0 (capture, ack, go to ACK0).
  - Counter reaches `TIMEOUT_CYC`-1 with no request: pulse `frame_err`, go to IDLE.
  - The counter saturates and never wraps.
- **State ACK1.** When `req_s`=0: `Ack_out`<=0, go to IDLE, and register the outputs in that same edge. So `interboard_en` is high in the first cycle `Ack_out` is low.
- **Latency.**
  - `Request_in` rise to `Ack_out` rise: `SYNC_STAGES`+1 cycles.
  - `Request_in` fall (beat 1) to `interboard_en`: `SYNC_STAGES`+1 cycles.
- **Output holding.**
  - `msg_type` and `number` update only on a valid frame.
  - `frame_err` and `interboard_en` are never high in the same cycle.
- **Number range.** A number > 24 is still delivered; range checking belongs to the consumer.
- **Reset mid-frame.** `rst` in any state forces IDLE with `Ack_out`=0 on the next edge, and no pulse is produced. A peer stuck with `Request_in` high is then re-acked as a new beat.

Optional Feature:
- Macro `INTER_PARITY_EN`.
- **Defined:** in ACK1, a par mismatch against the received type and number pulses `frame_err` instead of `interboard_en`/`interboard_rst`; the held outputs do not update.
- **Undefined:** par bits are ignored and every well-ordered frame is delivered.

Test Plan:
- **Normal message.** Send type=3'd2, num=5'd17 (beats 6'b101010, 6'b000110) with a well-behaved peer → `Ack_out` toggles twice; one `interboard_en` pulse; type=2, number=17; `frame_err` stays 0.
- **Reset message.** Frame with type=3'd7, num=0 → `interboard_en` and `interboard_rst` pulse in the same cycle; number=0.
- **Orphan beat 1.** Beat 6'b011100 sent from IDLE → it is acked; one `frame_err` pulse after `Request_in` falls; no `interboard_en`.
- **Timeout.** With `TIMEOUT_CYC`=16, send beat 0 only → `frame_err` pulses 16 cycles after entering WAIT1; FSM in IDLE; a following complete frame with type=1, num=3 is delivered.
- **Parity error.** With `INTER_PARITY_EN` defined, send a frame whose par bits are inverted → `frame_err` pulse and outputs unchanged. Without the macro, the same frame → `interboard_en` with the sent values.
- **Reset mid-frame.** Assert `rst` for 1 cycle while in ACK1 → `Ack_out`=0 on the next cycle; no `interboard_en`; all outputs 0.

Source files
------------

// File: rtl/interboard_receiver.sv
// Receive side of the inter-board 4-phase link: synchronises Request_in, acks each beat and
// rebuilds two-beat {type, number} frames. Optional parity check is enabled by INTER_PARITY_EN.
module interboard_receiver #(
  parameter int          TIMEOUT_CYC = 1_000_000,
  parameter logic [2:0]  RST_TYPE    = 3'd7,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic [2:0] interboard_msg_type,
  output logic [4:0] interboard_number,
  output logic       interboard_rst,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACK0, WAIT1, ACK1} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             cap_type_q, cap_type_d;
  logic [1:0]             cap_num_hi_q, cap_num_hi_d;
  logic [2:0]             cap_num_lo_q, cap_num_lo_d;
  logic [1:0]             cap_par_q, cap_par_d;
  logic                   bad_q, bad_d;
  logic                   ack_q, ack_d;
  logic                   en_q, en_d;
  logic                   rst_out_q, rst_out_d;
  logic                   err_q, err_d;
  logic [2:0]             type_q, type_d;
  logic [4:0]             num_q, num_d;
  logic                   req_s;
  logic [4:0]             full_num;
  logic                   par_ok;

  assign req_sync_d = {req_sync_q[SYNC_STAGES-2:0], Request_in};
  assign req_s      = req_sync_q[SYNC_STAGES-1];
  assign full_num   = {cap_num_hi_q, cap_num_lo_q};
`ifdef INTER_PARITY_EN
  assign par_ok     = (cap_par_q == {^cap_type_q, ^full_num});
`else
  assign par_ok     = 1'b1;
`endif

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a latch behind.
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_type_d   = cap_type_q;
    cap_num_hi_d = cap_num_hi_q;
    cap_num_lo_d = cap_num_lo_q;
    cap_par_d    = cap_par_q;
    bad_d        = bad_q;
    ack_d        = ack_q;
    type_d       = type_q;
    num_d        = num_q;
    en_d         = 1'b0;
    rst_out_d    = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_s) begin
          ack_d   = 1'b1;
          state_d = ACK0;
          if (inter_data_in[5]) begin
            cap_type_d   = inter_data_in[4:2];
            cap_num_hi_d = inter_data_in[1:0];
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      ACK0: begin
        if (!req_s) begin
          ack_d = 1'b0;
          if (bad_q) begin
            err_d   = 1'b1;
            bad_d   = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT1;
          end
        end
      end
      WAIT1: begin
        if (req_s) begin
          ack_d = 1'b1;
          if (!inter_data_in[5]) begin
            cap_num_lo_d = inter_data_in[4:2];
            cap_par_d    = inter_data_in[1:0];
            state_d      = ACK1;
          end else begin
            // A fresh beat 0 restarts the frame; the abandoned one is reported.
            err_d        = 1'b1;
            cap_type_d   = inter_data_in[4:2];
            cap_num_hi_d = inter_data_in[1:0];
            state_d      = ACK0;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACK1: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
          if (par_ok) begin
            en_d      = 1'b1;
            rst_out_d = (cap_type_q == RST_TYPE);
            type_d    = cap_type_q;
            num_d     = full_num;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with <= only, so every flop sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_sync_q   <= '0;
      cnt_q        <= '0;
      cap_type_q   <= '0;
      cap_num_hi_q <= '0;
      cap_num_lo_q <= '0;
      cap_par_q    <= '0;
      bad_q        <= 1'b0;
      ack_q        <= 1'b0;
      en_q         <= 1'b0;
      rst_out_q    <= 1'b0;
      err_q        <= 1'b0;
      type_q       <= '0;
      num_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_sync_q   <= req_sync_d;
      cnt_q        <= cnt_d;
      cap_type_q   <= cap_type_d;
      cap_num_hi_q <= cap_num_hi_d;
      cap_num_lo_q <= cap_num_lo_d;
      cap_par_q    <= cap_par_d;
      bad_q        <= bad_d;
      ack_q        <= ack_d;
      en_q         <= en_d;
      rst_out_q    <= rst_out_d;
      err_q        <= err_d;
      type_q       <= type_d;
      num_q        <= num_d;
    end
  end

  assign Ack_out             = ack_q;
  assign interboard_en       = en_q;
  assign interboard_rst      = rst_out_q;
  assign frame_err           = err_q;
  assign interboard_msg_type = type_q;
  assign interboard_number   = num_q;

endmodule
